usi_dma_hs_master: RTL and testbench
====================================

Name: usi_dma_hs_master

Overview:
- DMA-side peer of the USI block's request/acknowledge handshake.
- Answers the USI's dma_req_tx/dma_req_rx and moves one burst per request over an APB master port to the USI data register.
- Sends dma_ack_tx/dma_ack_rx back to the USI when each burst completes.
- Buffers data in two small FIFOs toward a valid/ready stream side (memory mover or test source).

Parameters:
- DATA_OFFSET, 32'h0000_0040: byte offset of the USI data register from cfg_base.
- BURST, 4: APB beats per request (power of 2, 1..FIFO_DEPTH).
- FIFO_DEPTH, 8: words per internal FIFO (power of 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- cfg_en  in  1  block enable.
- cfg_tx_en  in  1  service TX requests.
- cfg_rx_en  in  1  service RX requests.
- cfg_base  in  32  USI APB base address.
- dma_req_tx  in  1  USI TX request (level).
- dma_ack_tx  out  1  TX acknowledge.
- dma_req_rx  in  1  USI RX request (level).
- dma_ack_rx  out  1  RX acknowledge.
- paddr  out  32  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data (no pready; fixed two-cycle access).
- tx_data  in  32  stream word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  32  received word (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops a word.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; both FIFOs are emptied.
  - psel, penable, pwrite, dma_ack_tx, dma_ack_rx, busy, rx_valid = 0.
  - paddr and pwdata = 0.
  - tx_ready = 1 after reset completes.
  - Reset mid-burst aborts the burst immediately; no acknowledge is issued.
- FSM states: IDLE, SETUP, ACCESS, ACK.
- IDLE arbitration, evaluated only when cfg_en=1:
  - RX is eligible when dma_req_rx=1, cfg_rx_en=1 and RX FIFO free space >= BURST.
  - TX is eligible when dma_req_tx=1, cfg_tx_en=1 and TX FIFO count >= BURST.
  - If both are eligible, RX wins (overrun avoidance).
  - The winner is latched as dir; the beat counter is cleared; the FSM goes to SETUP.
- SETUP: psel=1, penable=0, paddr=cfg_base+DATA_OFFSET, pwrite=(dir==TX). For TX, pwdata = TX FIFO head. Next state is ACCESS.
- ACCESS: psel=1, penable=1.
  - At the end of the cycle, TX pops the FIFO head; RX pushes prdata.
  - The beat counter increments.
  - If it was the last beat (count==BURST-1), go to ACK; otherwise go to SETUP.
  - Throughput is 2 cycles per beat; psel stays high across beats.
- ACK: psel=0, penable=0.
  - The selected dma_ack_x=1 and is held while the matching dma_req_x=1 (4-phase handshake).
  - When dma_req_x is sampled 0, dma_ack_x drops on that edge and the FSM returns to IDLE.
  - A new request cannot be arbitrated in the same cycle the ack drops.
- cfg_en, cfg_tx_en and cfg_rx_en are sampled only in IDLE. Deasserting them mid-burst lets the burst and its ack complete.
- A request dropping before its burst completes is ignored. The burst finishes, then ACK sees req=0 and exits after one cycle with a one-cycle ack pulse.
- FIFOs:
  - A simultaneous push and pop on the same cycle is allowed at any fill level, including full and empty.
  - Count width is log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - tx_ready = (count < FIFO_DEPTH).
  - Writes while full are dropped; not possible if the stream side obeys ready.
  - rx_data is undefined when rx_valid=0.
- Address arithmetic is 32-bit unsigned with wrap-around.
- busy = (state != IDLE).

Test Plan:
- TX burst:
  - Stimulus: cfg_base=32'h4001_0000, push words 1,2,3,4, raise dma_req_tx.
  - Response: 4 write beats to 32'h4001_0040 with pwdata 1,2,3,4, each psel/penable 2 cycles; dma_ack_tx=1 the cycle after the 4th ACCESS; ack held until req drops, then 0 the next edge.
- RX burst:
  - Stimulus: dma_req_rx=1, prdata sequence A0..A3.
  - Response: 4 read beats; rx_data pops A0,A1,A2,A3 in order; dma_ack_rx pulses as above.
- Arbitration:
  - Stimulus: dma_req_tx and dma_req_rx rise the same cycle, both eligible.
  - Response: RX burst first; after its ack completes, the TX burst starts; no interleaved beats.
- Gating:
  - Stimulus: TX FIFO holds 3 words with dma_req_tx=1.
  - Response: no APB activity and busy=0; pushing a 4th word starts SETUP within 2 cycles.
  - Stimulus: RX FIFO with 5 words, FIFO_DEPTH=8.
  - Response: RX request not serviced until one word is popped.
- Reset mid-operation:
  - Stimulus: rst_n=0 during the 2nd ACCESS of a TX burst.
  - Response: next edge psel=penable=ack=0, tx_ready=1, rx_valid=0; afterwards a fresh request runs a full 4-beat burst.
- Early request drop:
  - Stimulus: dma_req_rx falls after beat 1.
  - Response: remaining 3 beats still run; dma_ack_rx high exactly 1 cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/usi_dma_hs_master.sv
// rtl/usi_dma_hs_master.sv - DMA-side request/ack peer moving bursts between stream FIFOs and the USI data register over APB
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cfg_en/cfg_tx_en/cfg_rx_en      enables, sampled only while idle
//   cfg_base                        USI APB base address
//   dma_req_tx/rx, dma_ack_tx/rx    4-phase request/acknowledge handshake with the USI
//   paddr/psel/penable/pwrite/pwdata/prdata   APB master (fixed two-cycle access)
//   tx_data/tx_valid/tx_ready       stream into the TX FIFO
//   rx_data/rx_valid/rx_ready       first-word fall-through stream out of the RX FIFO
//   busy                            FSM not idle
module usi_dma_hs_master #(
    parameter logic [31:0] DATA_OFFSET = 32'h0000_0040,
    parameter int          BURST       = 4,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_tx_en,
    input  logic        cfg_rx_en,
    input  logic [31:0] cfg_base,
    input  logic        dma_req_tx,
    output logic        dma_ack_tx,
    input  logic        dma_req_rx,
    output logic        dma_ack_rx,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

    state_t          state, state_nxt;
    logic            dir_tx, dir_tx_nxt;
    logic [CW-1:0]   beat, beat_nxt;
    logic            tx_pop, rx_push;

    // TX FIFO
    logic [31:0]     tx_mem [FIFO_DEPTH];
    logic [PW-1:0]   tx_wr, tx_rd;
    logic [CW-1:0]   tx_cnt;
    logic            tx_push;

    assign tx_ready = (tx_cnt < CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign tx_push  = tx_valid && (tx_ready || tx_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end

    // RX FIFO
    logic [31:0]     rx_mem [FIFO_DEPTH];
    logic [PW-1:0]   rx_wr, rx_rd;
    logic [CW-1:0]   rx_cnt;
    logic            rx_pop, rx_push_ok;

    assign rx_valid   = (rx_cnt != '0);
    assign rx_data    = rx_mem[rx_rd];
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_push_ok = rx_push && ((rx_cnt < CW'(FIFO_DEPTH)) || rx_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push_ok) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)     rx_rd <= rx_rd + 1'b1;
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wr] <= prdata;
    end

    // Handshake / APB FSM
    logic rx_elig, tx_elig, last_beat;

    // Only start a burst that can run to completion without stalling.
    assign rx_elig   = dma_req_rx && cfg_rx_en && (rx_cnt <= CW'(FIFO_DEPTH - BURST));
    assign tx_elig   = dma_req_tx && cfg_tx_en && (tx_cnt >= CW'(BURST));
    assign last_beat = (beat == CW'(BURST - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir_tx <= 1'b0;
            beat   <= '0;
        end else begin
            state  <= state_nxt;
            dir_tx <= dir_tx_nxt;
            beat   <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        dir_tx_nxt = dir_tx;
        beat_nxt   = beat;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = '0;
        pwdata     = '0;
        dma_ack_tx = 1'b0;
        dma_ack_rx = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_en && (rx_elig || tx_elig)) begin
                    // RX has priority to avoid overrunning the USI receiver.
                    dir_tx_nxt = !rx_elig;
                    beat_nxt   = '0;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                psel      = 1'b1;
                paddr     = cfg_base + DATA_OFFSET;
                pwrite    = dir_tx;
                pwdata    = dir_tx ? tx_mem[tx_rd] : '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel      = 1'b1;
                penable   = 1'b1;
                paddr     = cfg_base + DATA_OFFSET;
                pwrite    = dir_tx;
                pwdata    = dir_tx ? tx_mem[tx_rd] : '0;
                tx_pop    = dir_tx;
                rx_push   = !dir_tx;
                beat_nxt  = beat + 1'b1;
                state_nxt = last_beat ? ACK : SETUP;
            end
            ACK: begin
                if (dir_tx) begin
                    dma_ack_tx = 1'b1;
                    if (!dma_req_tx) state_nxt = IDLE;
                end else begin
                    dma_ack_rx = 1'b1;
                    if (!dma_req_rx) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usi_dma_hs_master.sv
// tb/tb_usi_dma_hs_master.sv - self-checking bench for usi_dma_hs_master
module tb_usi_dma_hs_master;

    logic        clk;
    logic        rst_n;
    logic        cfg_en, cfg_tx_en, cfg_rx_en;
    logic [31:0] cfg_base;
    logic        dma_req_tx, dma_ack_tx, dma_req_rx, dma_ack_rx;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        busy;

    usi_dma_hs_master dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en),
        .cfg_base(cfg_base),
        .dma_req_tx(dma_req_tx), .dma_ack_tx(dma_ack_tx),
        .dma_req_rx(dma_req_rx), .dma_ack_rx(dma_ack_rx),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] tx_exp[$];
    logic [31:0] rx_exp[$];
    logic        beat_log[$];
    int          wr_beats = 0;
    int          rd_beats = 0;
    int          rx_pops  = 0;
    logic [31:0] prdata_next = 32'h0000_00A0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // APB slave model + scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (psel && penable) begin
                chk("paddr", paddr, cfg_base + 32'h0000_0040);
                beat_log.push_back(pwrite);
                if (pwrite) begin
                    wr_beats++;
                    if (tx_exp.size() == 0) chk("tx_scoreboard_empty", 32'd1, 32'd0);
                    else chk("pwdata", pwdata, tx_exp.pop_front());
                end else begin
                    rd_beats++;
                    prdata = prdata_next;
                    rx_exp.push_back(prdata_next);
                    prdata_next = prdata_next + 1;
                end
            end
            if (rx_valid && rx_ready) begin
                rx_pops++;
                if (rx_exp.size() == 0) chk("rx_scoreboard_empty", 32'd1, 32'd0);
                else chk("rx_data", rx_data, rx_exp.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dma_req_tx = 1'b0;
        dma_req_rx = 1'b0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        rst_n      = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        beat_log.delete();
        wr_beats = 0;
        rd_beats = 0;
        rx_pops  = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_tx(input logic [31:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        tx_exp.push_back(v);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_ack(input bit rx, input int n);
        bit got = 0;
        for (int i = 0; i < n; i++) begin
            if (rx ? dma_ack_rx : dma_ack_tx) begin
                got = 1;
                break;
            end
            tick();
        end
        chk(rx ? "wait_ack_rx" : "wait_ack_tx", 32'(got), 32'd1);
    endtask

    task automatic drain_rx();
        bit done = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!rx_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        rx_ready = 1'b0;
        chk("drain_rx", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic en, tx_en, rx_en, rtx, rrx;
        int   words;
        logic exp_busy, exp_pwrite;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 1, 1, 1, 0, 4, 1, 1};  // TX with full burst queued
        vecs[1] = '{1, 1, 1, 1, 0, 3, 0, 0};  // TX short of a burst
        vecs[2] = '{1, 1, 1, 0, 1, 0, 1, 0};  // RX with empty FIFO
        vecs[3] = '{1, 1, 1, 1, 1, 4, 1, 0};  // both eligible: RX wins
        vecs[4] = '{0, 1, 1, 1, 1, 4, 0, 0};  // block disabled
        vecs[5] = '{1, 1, 0, 1, 1, 4, 1, 1};  // RX disabled: TX taken
        vecs[6] = '{1, 0, 1, 1, 0, 4, 0, 0};  // TX disabled
        vecs[7] = '{1, 1, 0, 0, 1, 0, 0, 0};  // RX disabled, RX only

        cfg_en = 1; cfg_tx_en = 1; cfg_rx_en = 1;
        cfg_base = 32'h4001_0000;
        tx_data = '0;
        prdata = '0;
        do_reset();

        // Reset state
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_acks", 32'({dma_ack_tx, dma_ack_rx}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);

        // Arbitration / gating table
        for (int r = 0; r < 8; r++) begin
            do_reset();
            cfg_en = vecs[r].en; cfg_tx_en = vecs[r].tx_en; cfg_rx_en = vecs[r].rx_en;
            for (int i = 0; i < vecs[r].words; i++) push_tx(32'h100 + 32'(i));
            dma_req_tx = vecs[r].rtx;
            dma_req_rx = vecs[r].rrx;
            tick(); tick(); tick();
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(vecs[r].exp_busy));
            chk($sformatf("tbl%0d_psel", r), 32'(psel), 32'(vecs[r].exp_busy));
            if (vecs[r].exp_busy) chk($sformatf("tbl%0d_dir", r), 32'(pwrite), 32'(vecs[r].exp_pwrite));
            cfg_en = 1; cfg_tx_en = 1; cfg_rx_en = 1;
        end

        // TX burst with exact cycle pattern
        do_reset();
        for (int i = 1; i <= 4; i++) push_tx(32'(i));
        chk("tx_ready_after_4", 32'(tx_ready), 1);
        dma_req_tx = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("tx_psel_%0d", k), 32'(psel), 1);
            chk($sformatf("tx_penable_%0d", k), 32'(penable), 32'(k % 2 == 0));
        end
        tick();
        chk("tx_ack_rise", 32'(dma_ack_tx), 1);
        chk("tx_ack_psel", 32'(psel), 0);
        tick(); tick(); tick();
        chk("tx_ack_hold", 32'(dma_ack_tx), 1);
        dma_req_tx = 1'b0;
        tick();
        chk("tx_ack_drop", 32'(dma_ack_tx), 0);
        chk("tx_idle", 32'(busy), 0);
        chk("tx_beats", 32'(wr_beats), 4);

        // RX burst, address wrap-around
        do_reset();
        cfg_base = 32'hFFFF_FFF0;
        dma_req_rx = 1'b1;
        repeat (9) tick();
        chk("rx_ack_rise", 32'(dma_ack_rx), 1);
        dma_req_rx = 1'b0;
        tick();
        chk("rx_ack_drop", 32'(dma_ack_rx), 0);
        drain_rx();
        chk("rx_pops", 32'(rx_pops), 4);
        cfg_base = 32'h4001_0000;

        // Simultaneous requests: RX burst, then TX burst, no interleave
        do_reset();
        for (int i = 0; i < 4; i++) push_tx(32'h200 + 32'(i));
        rx_ready = 1'b1;
        dma_req_tx = 1'b1;
        dma_req_rx = 1'b1;
        wait_ack(1, 30);
        begin
            int nw = 0;
            foreach (beat_log[i]) nw += int'(beat_log[i]);
            chk("arb_rx_beats", 32'(beat_log.size()), 4);
            chk("arb_rx_no_writes", 32'(nw), 0);
        end
        dma_req_rx = 1'b0;
        wait_ack(0, 30);
        begin
            int nw = 0;
            for (int i = 4; i < beat_log.size(); i++) nw += int'(beat_log[i]);
            chk("arb_total_beats", 32'(beat_log.size()), 8);
            chk("arb_tx_writes", 32'(nw), 4);
        end
        dma_req_tx = 1'b0;
        tick();
        drain_rx();

        // TX gating on FIFO level
        do_reset();
        for (int i = 0; i < 3; i++) push_tx(32'h300 + 32'(i));
        dma_req_tx = 1'b1;
        repeat (4) tick();
        chk("gate_tx_busy", 32'(busy), 0);
        chk("gate_tx_psel", 32'(psel), 0);
        push_tx(32'h303);
        begin
            bit seen = 0;
            for (int i = 0; i < 2; i++) begin
                tick();
                if (psel) seen = 1;
            end
            chk("gate_tx_start", 32'(seen), 1);
        end

        // RX gating on FIFO free space
        do_reset();
        dma_req_rx = 1'b1;
        wait_ack(1, 20);
        dma_req_rx = 1'b0;
        tick();
        dma_req_rx = 1'b1;
        wait_ack(1, 20);
        dma_req_rx = 1'b0;
        tick();
        rx_ready = 1'b1;
        repeat (3) tick();
        rx_ready = 1'b0;
        chk("gate_rx_pop3", 32'(rx_pops), 3);
        dma_req_rx = 1'b1;
        repeat (4) tick();
        chk("gate_rx_blocked", 32'(busy), 0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        chk("gate_rx_started", 32'(busy), 1);
        dma_req_rx = 1'b0;
        begin
            bit idle = 0;
            for (int i = 0; i < 20; i++) begin
                if (!busy) begin
                    idle = 1;
                    break;
                end
                tick();
            end
            chk("gate_rx_idle", 32'(idle), 1);
        end
        drain_rx();
        chk("gate_rx_total_pops", 32'(rx_pops), 12);

        // Reset in the 2nd ACCESS of a TX burst
        do_reset();
        for (int i = 0; i < 4; i++) push_tx(32'h400 + 32'(i));
        dma_req_tx = 1'b1;
        repeat (4) tick();
        chk("mid_in_access", 32'({psel, penable}), 32'b11);
        rst_n = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        tick();
        chk("mid_psel", 32'(psel), 0);
        chk("mid_penable", 32'(penable), 0);
        chk("mid_ack", 32'(dma_ack_tx), 0);
        chk("mid_tx_ready", 32'(tx_ready), 1);
        chk("mid_rx_valid", 32'(rx_valid), 0);
        chk("mid_busy", 32'(busy), 0);
        dma_req_tx = 1'b0;
        rst_n = 1'b1;
        wr_beats = 0;
        tick();
        for (int i = 5; i <= 8; i++) push_tx(32'(i));
        dma_req_tx = 1'b1;
        wait_ack(0, 20);
        chk("mid_fresh_beats", 32'(wr_beats), 4);
        dma_req_tx = 1'b0;
        tick();

        // Request dropped after the first beat
        do_reset();
        dma_req_rx = 1'b1;
        repeat (3) tick();
        dma_req_rx = 1'b0;
        begin
            int ack_cycles = 0;
            for (int i = 0; i < 20; i++) begin
                if (dma_ack_rx) ack_cycles++;
                tick();
            end
            chk("drop_ack_cycles", 32'(ack_cycles), 1);
        end
        chk("drop_beats", 32'(rd_beats), 4);
        chk("drop_idle", 32'(busy), 0);
        drain_rx();
        chk("drop_pops", 32'(rx_pops), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
